audio_dac_ser: RTL and testbench

AUDIO_DAC_SER -- requirements
Module: audio_dac_ser

---
 rtl/audio_dac_ser.sv | 118 +++++++++++
 tb/tb_audio_dac_ser.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_ser.sv
// audio_dac_ser: sample FIFO feeding a 32-slot mono-duplicated serial DAC stream.
// Left-justified by default; define AUDIO_DAC_I2S_DELAY_EN for I2S one-slot data delay.
module audio_dac_ser #(
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in_sample,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        aud_bclk,
   output logic        aud_lrck,
   output logic        aud_dacdat,
   output logic        underflow
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          DIV_M1    = BCLK_DIV - 1;
   localparam logic [7:0]  DIV_MAX   = DIV_M1[7:0];
   localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          full_q;
   logic [7:0]    div_q;
   logic          bclk_q;
   logic          lrck_q;
   logic          dacdat_q;
   logic          underflow_q;
   logic [4:0]    slot_q;
   logic [4:0]    slot_d;
   logic [15:0]   sample_q;
   logic [15:0]   sample_d;
   logic          div_wrap;
   logic          fall;
   logic          frame_start;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [3:0]    bit_idx;
   logic          tx_bit;

   always_comb begin
      fifo_empty  = (count_q == '0);
      push        = in_valid & ~full_q;
      div_wrap    = (div_q == DIV_MAX);
      fall        = div_wrap & bclk_q;
      slot_d      = slot_q + 5'd1;
      frame_start = fall & (slot_q == 5'd31);
      pop         = frame_start & ~fifo_empty;
      count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      sample_d    = sample_q;
      if (frame_start) begin
         sample_d = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
      end
`ifdef AUDIO_DAC_I2S_DELAY_EN
      // Slot k carries bit 16-k of the current word; slots 0/16 wrap to the LSB,
      // and slot 0 still sees the outgoing word because sample_q has not reloaded yet.
      bit_idx = 4'd0 - slot_d[3:0];
      tx_bit  = sample_q[bit_idx];
`else
      bit_idx = 4'd15 - slot_d[3:0];
      tx_bit  = sample_d[bit_idx];
`endif
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_sample;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q       <= '0;
         bclk_q      <= 1'b0;
         slot_q      <= 5'd31;
         lrck_q      <= 1'b0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
         sample_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
      end else begin
         div_q       <= div_wrap ? 8'd0 : div_q + 8'd1;
         underflow_q <= frame_start & fifo_empty;
         if (div_wrap) begin
            bclk_q <= ~bclk_q;
         end
         // Everything visible to the DAC moves only on the falling BCLK transition.
         if (fall) begin
            slot_q   <= slot_d;
            lrck_q   <= slot_d[4];
            dacdat_q <= tx_bit;
            sample_q <= sample_d;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_CNT);
      end
   end

   assign in_ready   = ~full_q;
   assign aud_bclk   = bclk_q;
   assign aud_lrck   = lrck_q;
   assign aud_dacdat = dacdat_q;
   assign underflow  = underflow_q;
endmodule

// File: tb/tb_audio_dac_ser.sv
// Bench for audio_dac_ser: outputs are predicted from the clk count since reset release
// and a FIFO queue model, then compared cycle by cycle.
module tb_audio_dac_ser;
   localparam int D     = 2;
   localparam int DEPTH = 4;
   localparam int SLOT  = 2 * D;
   localparam int FRAME = 64 * D;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] in_sample = 16'h0000;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        aud_bclk;
   logic        aud_lrck;
   logic        aud_dacdat;
   logic        underflow;
   logic [4:0]  dut_vec;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          p;
   logic [15:0] mq[$];
   logic [15:0] m_cur;
   logic [15:0] m_prev;
   bit          m_uf;
   bit          m_ready;

   audio_dac_ser #(.BCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .in_sample(in_sample), .in_valid(in_valid),
      .in_ready(in_ready), .aud_bclk(aud_bclk), .aud_lrck(aud_lrck),
      .aud_dacdat(aud_dacdat), .underflow(underflow)
   );

   always #5 clk = ~clk;
   assign dut_vec = {aud_bclk, aud_lrck, aud_dacdat, underflow, in_ready};

   // Expected {bclk, lrck, dacdat, underflow, in_ready} after the p-th rising edge.
   function automatic logic [4:0] exp_vec();
      logic b, l, d;
      int n, s, k;
      b = ((p / D) % 2) == 1;
      l = 1'b0;
      d = 1'b0;
      if (p >= SLOT) begin
         n = (p - SLOT) / SLOT;
         s = n % 32;
         k = s % 16;
         l = (s >= 16);
`ifdef AUDIO_DAC_I2S_DELAY_EN
         if (k == 0) d = (s == 0) ? m_prev[0] : m_cur[0];
         else        d = m_cur[16 - k];
`else
         d = m_cur[15 - k];
`endif
      end
      return {b, l, d, m_uf, m_ready};
   endfunction

   task automatic model_reset();
      p = 0;
      mq.delete();
      m_cur   = 16'h0000;
      m_prev  = 16'h0000;
      m_uf    = 1'b0;
      m_ready = 1'b1;
   endtask

   task automatic model_edge(input bit v, input logic [15:0] s, output bit acc);
      acc = v && (mq.size() < DEPTH);
      p++;
      m_uf = 1'b0;
      if (p >= SLOT && ((p - SLOT) % FRAME) == 0) begin
         m_prev = m_cur;
         if (mq.size() > 0) m_cur = mq.pop_front();
         else begin
            m_cur = 16'h0000;
            m_uf  = 1'b1;
         end
      end
      if (acc) mq.push_back(s);
      m_ready = (mq.size() < DEPTH);
   endtask

   task automatic cyc(input bit v, input logic [15:0] s, output bit acc);
      in_valid  = v;
      in_sample = s;
      @(posedge clk);
      model_edge(v, s, acc);
      #1;
   endtask

   task automatic apply_reset();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bit acc;
      reset_n = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (dut_vec[4:1] !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0000", dut_vec[4:1]);
      end
      @(posedge clk);
      #1;
      model_reset();
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      for (int i = 0; i < SLOT + 6; i++) begin
         cyc(1'b0, 16'h0000, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_startup p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_format();
      bit acc;
      logic [31:0] cap0;
      logic [2:0]  cap1;
      int n;
      cap0 = '0;
      cap1 = '0;
      apply_reset();
      for (int i = 0; i < SLOT + 2 * FRAME + 4 * SLOT; i++) begin
`ifdef AUDIO_DAC_I2S_DELAY_EN
         if (i == 0)      cyc(1'b1, 16'h8001, acc);
         else if (i == 1) cyc(1'b1, 16'h4000, acc);
         else             cyc(1'b0, 16'h0000, acc);
`else
         cyc(i == 0, 16'h8001, acc);
`endif
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL format p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
         if (p >= SLOT && ((p - SLOT) % SLOT) == 0) begin
            n = (p - SLOT) / SLOT;
            if (n < 32) cap0[31 - n] = aud_dacdat;
            if (n >= 64 && n < 67) cap1[n - 64] = aud_dacdat;
         end
      end
`ifdef AUDIO_DAC_I2S_DELAY_EN
      checks++;
      if (cap0 !== {1'b0, 15'h4000, 1'b1, 15'h4000}) begin
         errors++;
         $display("FAIL i2s_frame1_bits got=%h exp=%h", cap0, {1'b0, 15'h4000, 1'b1, 15'h4000});
      end
      checks++;
      if (cap1 !== 3'b101) begin
         errors++;
         $display("FAIL i2s_frame2_slots012 got=%b exp=101", cap1);
      end
`else
      checks++;
      if (cap0 !== {16'h8001, 16'h8001}) begin
         errors++;
         $display("FAIL lj_frame1_bits got=%h exp=80018001", cap0);
      end
`endif
   endtask

   task automatic test_idle_underflow();
      bit acc;
      int pulses;
      pulses = 0;
      apply_reset();
      for (int i = 0; i < SLOT + 2 * FRAME - 1; i++) begin
         cyc(1'b0, 16'h0000, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL idle p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
         if (underflow === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL idle_underflow_count got=%0d exp=2", pulses);
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      logic [15:0] smp [5];
      int k, acc_p;
      for (int i = 0; i < 5; i++) smp[i] = 16'($urandom);
      apply_reset();
      for (int i = 0; i < SLOT + 1; i++) cyc(1'b0, 16'h0000, acc);
      k = 0;
      acc_p = -1;
      while (k < 5 && p < SLOT + 2 * FRAME) begin
         cyc(1'b1, smp[k], acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_fill p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
         if (acc) begin
            if (k == 4) acc_p = p;
            k++;
         end
      end
      checks++;
      if (acc_p != SLOT + FRAME + 1) begin
         errors++;
         $display("FAIL b2b_fifth_accept_edge got=%0d exp=%0d", acc_p, SLOT + FRAME + 1);
      end
      for (int i = 0; i < 5 * FRAME; i++) begin
         cyc(1'b0, 16'h0000, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_drain p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_order();
      bit acc;
      logic [15:0] vals [3];
      logic [3:0] uf_hist;
      vals[0] = 16'h1234;
      vals[1] = 16'hFFFF;
      vals[2] = 16'h0000;
      uf_hist = '0;
      apply_reset();
      for (int i = 0; i < SLOT + 3 * FRAME + 2; i++) begin
         if (i < 3) cyc(1'b1, vals[i], acc);
         else       cyc(1'b0, 16'h0000, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL order p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
         if (p >= SLOT && ((p - SLOT) % FRAME) == 0) uf_hist[(p - SLOT) / FRAME] = underflow;
      end
      checks++;
      if (uf_hist !== 4'b1000) begin
         errors++;
         $display("FAIL order_underflow_frames got=%b exp=1000", uf_hist);
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      bit uf_seen;
      apply_reset();
      for (int i = 0; i < SLOT + 20 * SLOT + 1; i++) begin
         cyc(i < 3, 16'hFFFF, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_pre p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (dut_vec[4:1] !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_outputs got=%b exp=0000", dut_vec[4:1]);
      end
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset_n = 1'b1;
      uf_seen = 1'b0;
      for (int i = 0; i < SLOT + FRAME + 2; i++) begin
         cyc(1'b0, 16'h0000, acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_post p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
         if (p == SLOT) uf_seen = underflow;
      end
      checks++;
      if (uf_seen !== 1'b1) begin
         errors++;
         $display("FAIL mid_first_frame_underflow got=%b exp=1", uf_seen);
      end
   endtask

   task automatic test_random();
      bit acc;
      int rate;
      apply_reset();
      for (int i = 0; i < 6 * FRAME; i++) begin
         rate = (i < 3 * FRAME) ? 1 : 30;
         cyc($urandom_range(0, 99) < rate, 16'($urandom), acc);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random p=%0d got=%b exp=%b", p, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_format();
      test_idle_underflow();
      test_back_to_back();
      test_order();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
